// File: rtl/fft16_frame_feeder.sv
// fft16_frame_feeder: ping-pong frame buffer that replays each full bank as one
// contiguous N_POINT-cycle valid burst, followed by an enforced idle gap.
module fft16_frame_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N_POINT    = 16,
    parameter int GAP_CYCLES = 20
) (
    input  logic                  sys_clk_i,
    input  logic                  rst_n_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_real_i,
    input  logic [DATA_WIDTH-1:0] s_imag_i,
    input  logic                  flush_i,
    output logic                  data_out_valid_o,
    output logic [DATA_WIDTH-1:0] xn_real_o,
    output logic [DATA_WIDTH-1:0] xn_imag_o,
    output logic [15:0]           frame_cnt_o
);
    localparam int AW = $clog2(N_POINT);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    state_t                  state_q, state_d;
    logic [2*DATA_WIDTH-1:0] mem_q [2][N_POINT];
    logic [1:0]              full_q, full_d;
    logic                    wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   real_q, real_d, imag_q, imag_d;
    logic [15:0]             frame_q, frame_d;
    logic                    hs, wr_last, gap_done, emit, rd_last;
    logic [2*DATA_WIDTH-1:0] rd_word;

    assign s_ready_o = !full_q[wr_bank_q];
    // flush beats a coincident handshake: the sample is dropped entirely
    assign hs       = s_valid_i && s_ready_o && !flush_i;
    assign wr_last  = hs && wr_addr_q == AW'(N_POINT - 1);
    assign gap_done = state_q == GAP && gap_q == GW'(GAP_CYCLES);
    // launching from IDLE or the end of a gap emits sample 0 on the same edge
    assign emit     = state_q == BURST || (full_q[rd_bank_q] && (state_q == IDLE || gap_done));
    assign rd_last  = emit && rd_addr_q == AW'(N_POINT - 1);
    assign rd_word  = mem_q[rd_bank_q][rd_addr_q];

    always_comb begin
        wr_addr_d = flush_i ? '0 : wr_addr_q + AW'(hs);
        wr_bank_d = wr_bank_q ^ wr_last;
        rd_addr_d = rd_addr_q + AW'(emit);
        rd_bank_d = rd_bank_q ^ rd_last;
        full_d    = full_q;
        if (wr_last) full_d[wr_bank_q] = 1'b1;
        if (rd_last) full_d[rd_bank_q] = 1'b0;
        frame_d   = frame_q + 16'(rd_last);
        gap_d     = state_q == GAP ? gap_q + GW'(1) : '0;
        state_d   = rd_last ? GAP : emit ? BURST : gap_done ? IDLE : state_q;
        valid_d   = emit;
        real_d    = emit ? rd_word[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
        imag_d    = emit ? rd_word[DATA_WIDTH-1:0] : '0;
    end

    always_ff @(posedge sys_clk_i) begin
        if (hs) mem_q[wr_bank_q][wr_addr_q] <= {s_real_i, s_imag_i};
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            gap_q     <= '0;
            valid_q   <= 1'b0;
            real_q    <= '0;
            imag_q    <= '0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            gap_q     <= gap_d;
            valid_q   <= valid_d;
            real_q    <= real_d;
            imag_q    <= imag_d;
            frame_q   <= frame_d;
        end
    end

    assign data_out_valid_o = valid_q;
    assign xn_real_o        = real_q;
    assign xn_imag_o        = imag_q;
    assign frame_cnt_o      = frame_q;
endmodule

// File: tb/tb_fft16_frame_feeder.sv
// tb_fft16_frame_feeder: directed table-driven bench; a negedge monitor logs every
// valid output cycle and each test compares that log against expected bursts.
module tb_fft16_frame_feeder;
    typedef struct { logic [7:0] re_in, im_in, re_exp, im_exp; } vec_t;
    typedef struct { int cyc; logic [7:0] re, im; logic [15:0] fc; } rec_t;

    logic        clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, flush = 1'b0;
    logic [7:0]  s_real = '0, s_imag = '0;
    logic        s_ready, dout_valid;
    logic [7:0]  xr, xi;
    logic [15:0] fcnt;

    int   cyc = 0, n_cmp = 0, n_bad = 0, zero_err = 0, fc = 0;
    vec_t tab [48];
    int   acc [48];
    rec_t mon_q [$];
    rec_t exp_q [$];

    fft16_frame_feeder dut (
        .sys_clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_real_i(s_real), .s_imag_i(s_imag), .flush_i(flush),
        .data_out_valid_o(dout_valid), .xn_real_o(xr), .xn_imag_o(xi), .frame_cnt_o(fcnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid) mon_q.push_back('{cyc, xr, xi, fcnt});
        else if (xr != 8'd0 || xi != 8'd0) zero_err++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push(input vec_t v, output int c);
        logic r;
        s_valid = 1'b1;
        s_real  = v.re_in;
        s_imag  = v.im_in;
        c = -1;
        for (int t = 0; t < 200 && c < 0; t++) begin
            @(negedge clk) r = s_ready;
            @(posedge clk) #1;
            if (r) c = cyc;
        end
        if (c < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: actual=no_handshake required=handshake");
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_burst(input int first, input int k0);
        for (int i = 0; i < 16; i++)
            exp_q.push_back('{first + i, tab[k0+i].re_exp, tab[k0+i].im_exp, 16'(fc + (i == 15 ? 1 : 0))});
        fc++;
    endtask

    task automatic compare(input string tag);
        chk({tag, " count"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            chk($sformatf("%s[%0d] cycle", tag, i), mon_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s[%0d] real", tag, i), mon_q[i].re, exp_q[i].re);
            chk($sformatf("%s[%0d] imag", tag, i), mon_q[i].im, exp_q[i].im);
            chk($sformatf("%s[%0d] frame_cnt", tag, i), mon_q[i].fc, exp_q[i].fc);
        end
        chk({tag, " idle_data_zero"}, zero_err, 0);
        mon_q.delete();
        exp_q.delete();
        zero_err = 0;
    endtask

    initial begin
        for (int k = 0; k < 48; k++) begin
            if (k < 16) begin
                tab[k].re_in = 8'(k);
                tab[k].im_in = 8'(-k);
            end else if (k < 32) begin
                tab[k].re_in = 8'(-128 + 17 * (k - 16));
                tab[k].im_in = 8'(127 - 17 * (k - 16));
            end else begin
                tab[k].re_in = 8'(k * 37);
                tab[k].im_in = 8'(~k);
            end
            tab[k].re_exp = tab[k].re_in;
            tab[k].im_exp = tab[k].im_in;
        end

        #1;
        chk("reset ready", s_ready, 1);
        chk("reset valid", dout_valid, 0);
        chk("reset real", xr, 0);
        chk("reset imag", xi, 0);
        chk("reset frame_cnt", fcnt, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("post_reset ready", s_ready, 1);

        // single frame: real = k, imag = -k
        for (int k = 0; k < 16; k++) push(tab[k], acc[k]);
        idle(40);
        add_burst(acc[15] + 1, 0);
        compare("single");

        // 48 samples held valid at full rate
        for (int k = 0; k < 48; k++) push(tab[k], acc[k]);
        @(negedge clk);
        chk("both_full ready", s_ready, 0);
        chk("stream no_stall", acc[47] - acc[0], 47);
        idle(100);
        add_burst(acc[15] + 1, 0);
        add_burst(acc[15] + 37, 16);
        add_burst(acc[15] + 73, 32);
        compare("stream");

        // slow source: one sample every 3 cycles
        for (int k = 0; k < 32; k++) begin
            push(tab[k], acc[k]);
            idle(2);
        end
        idle(60);
        add_burst(acc[15] + 1, 0);
        add_burst(acc[31] + 1, 16);
        compare("slow");

        // flush after 7 accepted samples
        for (int k = 0; k < 7; k++) push(tab[32+k], acc[k]);
        s_valid = 1'b0;
        flush   = 1'b1;
        @(posedge clk) #1;
        flush = 1'b0;
        for (int k = 0; k < 16; k++) push(tab[16+k], acc[k]);
        idle(40);
        add_burst(acc[15] + 1, 16);
        compare("flush");

        // flush coinciding with a handshake drops that sample
        for (int k = 0; k < 5; k++) push(tab[40+k], acc[k]);
        flush = 1'b1;
        push(tab[47], acc[0]);
        flush = 1'b0;
        for (int k = 0; k < 16; k++) push(tab[k], acc[k]);
        idle(40);
        add_burst(acc[15] + 1, 0);
        compare("flush_hs");

        // reset asserted during burst cycle 8
        for (int k = 0; k < 16; k++) push(tab[16+k], acc[k]);
        s_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset valid", dout_valid, 0);
        chk("midreset real", xr, 0);
        chk("midreset imag", xi, 0);
        chk("midreset frame_cnt", fcnt, 0);
        chk("midreset ready", s_ready, 1);
        chk("midreset partial_len", mon_q.size(), 8);
        mon_q.delete();
        zero_err = 0;
        fc = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        for (int k = 0; k < 16; k++) push(tab[k], acc[k]);
        idle(40);
        add_burst(acc[15] + 1, 0);
        compare("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft16_frame_feeder.md
# fft16_frame_feeder

Frame-scheduling transmitter on the serial sample input of the 16-point radix-4 FFT core. It accepts complex samples over a valid/ready stream and buffers them in two ping-pong banks of N_POINT entries. Each complete bank is replayed as one contiguous N_POINT-cycle valid burst, followed by an enforced idle gap, so the FFT core's rising-edge frame detection and 35-cycle processing window are never violated. It sits between the sample source and the FFT top.

## Interface
Parameters:
- DATA_WIDTH, 8, signed width of real and imaginary samples
- N_POINT, 16, samples per frame and per bank; power of two
- GAP_CYCLES, 20, exact count of low cycles on data_out_valid_o between bursts; must be ≥ 1

Ports:
- sys_clk_i  in  1  single clock, all logic on rising edge
- rst_n_i  in  1  reset: asynchronous, active-low
- s_valid_i  in  1  input sample valid
- s_ready_o  out  1  input ready; handshake = s_valid_i & s_ready_o
- s_real_i  in  DATA_WIDTH  signed input real part
- s_imag_i  in  DATA_WIDTH  signed input imaginary part
- flush_i  in  1  synchronous discard of the partially filled write bank
- data_out_valid_o  out  1  burst valid, drives the FFT's data_in_valid_i
- xn_real_o  out  DATA_WIDTH  signed burst real sample
- xn_imag_o  out  DATA_WIDTH  signed burst imaginary sample
- frame_cnt_o  out  16  count of completed bursts, wraps at 2^16

## Operation
- Storage: two banks × N_POINT × 2·DATA_WIDTH; per-bank full flag; wr_bank, wr_addr (log2 N_POINT bits), rd_bank, rd_addr.
- Write side: each handshake stores the sample at bank[wr_bank][wr_addr] and increments wr_addr. On the handshake at wr_addr = N_POINT-1: set full[wr_bank], toggle wr_bank, wr_addr → 0.
- s_ready_o = !full[wr_bank], combinational from registered flags, with no dependence on s_valid_i.
- flush_i: wr_addr → 0. A handshake in the same cycle is discarded and flush wins. Full banks and the burst in progress are unaffected.
- Read FSM states: IDLE, BURST, GAP.
  - IDLE: if full[rd_bank], go to BURST, emitting sample 0 on the same edge.
  - BURST: emit bank[rd_bank][rd_addr] in ascending address order. On the edge emitting address N_POINT-1: clear full[rd_bank], toggle rd_bank, increment frame_cnt_o, go to GAP.
  - GAP: count GAP_CYCLES cycles. On the final count, go to BURST if full[rd_bank], else IDLE.
- Set and clear of full flags never target the same bank on the same edge, because the writer never writes a full bank and the reader only reads a full bank. A set on one bank and a clear on the other on the same edge are both applied.
- Output data is registered. xn_real_o and xn_imag_o are 0 whenever data_out_valid_o = 0.
- Arithmetic: none. Data passes bit-exact and sign is preserved.

## Timing
- Reset values:
  - data_out_valid_o = 0, xn_real_o = 0, xn_imag_o = 0, frame_cnt_o = 0
  - state = IDLE, full flags = 0, all addresses and banks = 0
  - s_ready_o = 1, both during and after reset
- Latency: if the last sample of a bank is accepted at edge E and the FSM is IDLE, data_out_valid_o rises at edge E+1 carrying sample 0.
- Burst: data_out_valid_o is high for exactly N_POINT consecutive cycles, E+1 … E+N_POINT. frame_cnt_o increments at edge E+N_POINT.
- Gap: after any burst, data_out_valid_o is low for exactly GAP_CYCLES cycles when the next bank is already full, and longer otherwise. Minimum start-to-start spacing is N_POINT+GAP_CYCLES = 36 cycles by default.
- Backpressure:
  - With both banks full, s_ready_o = 0.
  - The emptied bank's flag clears at the last-sample edge, so s_ready_o rises in the following cycle.
  - Sustained input at 1 sample/cycle therefore stalls GAP_CYCLES cycles per frame.
- Reset mid-burst: outputs drop to 0 asynchronously, buffered data is lost, and no partial burst resumes.
- frame_cnt_o wraps 65535 → 0.

## Test plan
- Reset then single frame: 16 handshakes with samples k = 0..15, real = k and imag = −k, last at edge E → valid high E+1..E+16, output k at E+1+k, frame_cnt_o = 1, outputs 0 elsewhere.
- Back-to-back frames at full rate, 48 samples held valid → burst 1 at E+1, burst 2 starts at E+37 (20 low cycles between), s_ready_o low while both banks are full, every sample delivered in order with none lost.
- Slow source, 1 sample every 3 cycles → each burst is still 16 contiguous cycles, and the gap exceeds 20 cycles.
- Flush after 7 accepted samples, then 16 new samples → only the 16 new samples are emitted, with the same cycle timing as single-frame.
- Flush on the same cycle as a handshake → that sample is absent from the next burst.
- Reset asserted at burst cycle 8 → valid, data and frame_cnt_o go to 0 immediately, s_ready_o = 1, and a subsequent clean frame is emitted normally.
